// File: rtl/freq_div_ctrl.sv
// Run-time controller for NCH programmable clock dividers (CLK_in / 2N).
// Configuration changes take effect only at a falling CLK_out boundary so outputs never glitch.
module freq_div_ctrl #(
    parameter int NCH   = 3,
    parameter int CNT_W = 8
) (
    input  logic             CLK_in,
    input  logic             RST,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_ch,
    input  logic             cfg_en,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_err,
    output logic [NCH-1:0]   CLK_out,
    output logic [NCH-1:0]   active,
    output logic [NCH-1:0]   busy
);

    // state | meaning
    // IDLE  | channel stopped, CLK_out held low
    // RUN   | dividing with current N
    // PEND  | dividing with old N, new N loads at next falling toggle
    // STOP  | dividing with old N, stops at next falling toggle
    typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} state_t;

    state_t           state  [NCH];
    logic [CNT_W-1:0] cnt    [NCH];
    logic [CNT_W-1:0] n_cur  [NCH];
    logic [CNT_W-1:0] n_pend [NCH];

    logic           ch_ok;
    logic           tgt_busy;
    logic           accept;
    logic           reject;
    logic [NCH-1:0] take;
    logic [NCH-1:0] tc;

    always_comb begin
        ch_ok    = int'(cfg_ch) < NCH;
        tgt_busy = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(cfg_ch) == i && (state[i] == PEND || state[i] == STOP))
                tgt_busy = 1'b1;
        end
        cfg_ready = RST && !tgt_busy;
        accept    = cfg_valid && cfg_ready;
        reject    = accept && (!ch_ok || (cfg_en && cfg_div == '0));
        for (int i = 0; i < NCH; i++) begin
            take[i] = accept && !reject && (int'(cfg_ch) == i);
            tc[i]   = (state[i] != IDLE) && (cnt[i] == n_cur[i] - CNT_W'(1));
        end
    end

    always_ff @(posedge CLK_in) begin
        if (!RST) begin
            cfg_err <= 1'b0;
            CLK_out <= '0;
            active  <= '0;
            busy    <= '0;
            for (int i = 0; i < NCH; i++) begin
                state[i]  <= IDLE;
                cnt[i]    <= '0;
                n_cur[i]  <= '0;
                n_pend[i] <= '0;
            end
        end else begin
            cfg_err <= reject;
            for (int i = 0; i < NCH; i++) begin
                // Common divider step; a state below may override it.
                if (state[i] != IDLE) begin
                    if (tc[i]) begin
                        CLK_out[i] <= ~CLK_out[i];
                        cnt[i]     <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
                case (state[i])
                    IDLE: begin
                        CLK_out[i] <= 1'b0;
                        cnt[i]     <= '0;
                        if (take[i] && cfg_en) begin
                            state[i]  <= RUN;
                            n_cur[i]  <= cfg_div;
                            active[i] <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (take[i]) begin
                            busy[i] <= 1'b1;
                            if (cfg_en) begin
                                n_pend[i] <= cfg_div;
                                state[i]  <= PEND;
                            end else begin
                                state[i] <= STOP;
                            end
                        end
                    end
                    PEND: begin
                        if (tc[i] && CLK_out[i]) begin
                            n_cur[i] <= n_pend[i];
                            state[i] <= RUN;
                            busy[i]  <= 1'b0;
                        end
                    end
                    STOP: begin
                        if (tc[i] && CLK_out[i]) begin
                            state[i]  <= IDLE;
                            active[i] <= 1'b0;
                            busy[i]   <= 1'b0;
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

endmodule
